// File: rtl/intra4x4_pred_mode_encoding.sv
// Intra 4x4 prediction-mode encoder: turns the 16 chosen Intra4x4PredMode
// values of an MB into prev_intra4x4_pred_mode_flag / rem_intra4x4_pred_mode.
// It keeps its own neighbour context: the modes of the current MB, the right
// column of the left MB, and a line buffer holding the bottom row of the MB
// row above.
// Optional build macro INTRA4X4_MODE_CHECK_EN: out-of-range modes (>8) are
// clamped to DC (2) and flagged on the sticky mode_err_out.
module intra4x4_pred_mode_encoding #(
  parameter int MB_WIDTH  = 120,
  parameter int MB_X_BITS = 7,
  parameter int MB_Y_BITS = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mb_start_in,
  input  logic [MB_X_BITS-1:0] mb_x_in,
  input  logic [MB_Y_BITS-1:0] mb_y_in,
  input  logic                 mb_is_i4_in,
  input  logic                 mode_valid_in,
  input  logic [3:0]           mode_in,
  output logic                 mode_ready_out,
  output logic                 flag_valid_out,
  output logic                 prev_flag_out,
  output logic [2:0]           rem_mode_out,
  output logic [3:0]           blk_idx_out,
  input  logic                 flag_ready_in,
  output logic                 mb_done_out,
  output logic                 busy_out,
  output logic                 mode_err_out
);

  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, WB} state_t;

  state_t               state, state_nxt;
  logic [MB_X_BITS-1:0] mb_x;
  logic [MB_Y_BITS-1:0] mb_y;
  logic [3:0]           cnt;
  logic [63:0]          cur;       // nibble i = mode of block i
  logic [15:0]          left;      // nibble y = right column of left MB
  logic [15:0]          line_buf [MB_WIDTH];

  logic [1:0]  bx, by;
  logic [15:0] up_row;
  logic [3:0]  up_nib, left_nib, mpm, mode_eff;
  logic        unavail, accept, prev_c;
  logic [2:0]  rem_c;

  // luma4x4BlkIdx from block coordinates
  function automatic logic [3:0] blk_of(input logic [1:0] cx, input logic [1:0] cy);
    return {cy[1], cx[1], cy[0], cx[0]};
  endfunction

  assign bx     = {cnt[2], cnt[0]};
  assign by     = {cnt[3], cnt[1]};
  assign up_row = line_buf[mb_x];

  assign mode_ready_out = (state == RUN) && (!flag_valid_out || flag_ready_in);
  assign accept         = mode_ready_out && mode_valid_in;
  assign busy_out       = (state != IDLE);

`ifdef INTRA4X4_MODE_CHECK_EN
  logic mode_bad;
  assign mode_bad = (mode_in > 4'd8);
  assign mode_eff = mode_bad ? 4'd2 : mode_in;

  // sticky flag for any accepted out-of-range mode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                 mode_err_out <= 1'b0;
    else if (accept && mode_bad) mode_err_out <= 1'b1;
`else
  assign mode_eff     = mode_in;
  assign mode_err_out = 1'b0;
`endif

  // neighbour fetch, most-probable mode and rem coding for the current block
  always_comb begin
    up_nib   = (by == 2'd0) ? up_row[{bx, 2'b00} +: 4]
                            : cur[{blk_of(bx, by - 2'd1), 2'b00} +: 4];
    left_nib = (bx == 2'd0) ? left[{by, 2'b00} +: 4]
                            : cur[{blk_of(bx - 2'd1, by), 2'b00} +: 4];
    unavail  = ((mb_y == '0) && (by == 2'd0)) || ((mb_x == '0) && (bx == 2'd0));
    mpm      = unavail ? 4'd2 : ((up_nib < left_nib) ? up_nib : left_nib);
    prev_c   = (mode_eff == mpm);
    // mode <= 8 keeps mode-1 within 3 bits; larger inputs simply wrap
    rem_c    = prev_c ? 3'd0 :
               (mode_eff < mpm) ? mode_eff[2:0] : (mode_eff[2:0] - 3'd1);
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (mb_start_in) state_nxt = mb_is_i4_in ? RUN : FILL;
      FILL:  state_nxt = IDLE;
      RUN:   if (accept && cnt == 4'd15) state_nxt = DRAIN;
      DRAIN: if (!flag_valid_out || flag_ready_in) state_nxt = WB;
      WB:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // control, context registers and the output pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mb_x           <= '0;
      mb_y           <= '0;
      cnt            <= '0;
      cur            <= '0;
      left           <= 16'h2222;
      flag_valid_out <= 1'b0;
      prev_flag_out  <= 1'b0;
      rem_mode_out   <= '0;
      blk_idx_out    <= '0;
      mb_done_out    <= 1'b0;
    end else begin
      state       <= state_nxt;
      mb_done_out <= (state == FILL) || (state == WB);
      if (state == IDLE && mb_start_in) begin
        mb_x <= mb_x_in;
        mb_y <= mb_y_in;
        cnt  <= '0;
      end
      if (accept) begin
        cur[{cnt, 2'b00} +: 4] <= mode_eff;
        cnt            <= cnt + 4'd1;
        flag_valid_out <= 1'b1;
        prev_flag_out  <= prev_c;
        rem_mode_out   <= rem_c;
        blk_idx_out    <= cnt;
      end else if (flag_ready_in) begin
        flag_valid_out <= 1'b0;
      end
      if (state == FILL) left <= 16'h2222;
      else if (state == WB) left <= {cur[63:60], cur[55:52], cur[31:28], cur[23:20]};
    end
  end

  // line buffer update at MB end; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (state == FILL)
      line_buf[mb_x] <= 16'h2222;
    else if (state == WB)
      line_buf[mb_x] <= {cur[63:60], cur[59:56], cur[47:44], cur[43:40]};
  end

endmodule

// File: tb/tb_intra4x4_pred_mode_encoding.sv
// Directed bench for intra4x4_pred_mode_encoding: a short raster of MBs with
// hand-computed flag/rem expectations, a back-pressure stall, a non-I4 MB,
// asynchronous reset mid-MB and the out-of-range mode case.
module tb_intra4x4_pred_mode_encoding;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mb_start_in = 1'b0;
  logic [6:0] mb_x_in = '0;
  logic [6:0] mb_y_in = '0;
  logic       mb_is_i4_in = 1'b0;
  logic       mode_valid_in = 1'b0;
  logic [3:0] mode_in = '0;
  logic       mode_ready_out, flag_valid_out, prev_flag_out;
  logic [2:0] rem_mode_out;
  logic [3:0] blk_idx_out;
  logic       flag_ready_in = 1'b1;
  logic       mb_done_out, busy_out, mode_err_out;

  intra4x4_pred_mode_encoding dut (
    .clk(clk), .rst_n(rst_n), .mb_start_in(mb_start_in), .mb_x_in(mb_x_in),
    .mb_y_in(mb_y_in), .mb_is_i4_in(mb_is_i4_in), .mode_valid_in(mode_valid_in),
    .mode_in(mode_in), .mode_ready_out(mode_ready_out), .flag_valid_out(flag_valid_out),
    .prev_flag_out(prev_flag_out), .rem_mode_out(rem_mode_out), .blk_idx_out(blk_idx_out),
    .flag_ready_in(flag_ready_in), .mb_done_out(mb_done_out), .busy_out(busy_out),
    .mode_err_out(mode_err_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // captured output pairs and done pulses
  int         q_blk[$];
  int         q_cyc[$];
  int         q_done[$];
  logic       q_prev[$];
  logic [2:0] q_rem[$];

  always @(negedge clk) begin
    if (flag_valid_out && flag_ready_in) begin
      q_blk.push_back(int'(blk_idx_out));
      q_prev.push_back(prev_flag_out);
      q_rem.push_back(rem_mode_out);
      q_cyc.push_back(cyc);
    end
    if (mb_done_out) q_done.push_back(cyc);
  end

  // per-MB stimulus and expectations
  logic [3:0] m_v  [0:15];
  logic       ep_v [0:15];
  logic [2:0] er_v [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [3:0] m);
    for (int i = 0; i < 16; i++) begin
      m_v[i] = m; ep_v[i] = 1'b1; er_v[i] = 3'd0;
    end
  endtask

  task automatic set_exp(input int i, input logic p, input logic [2:0] r);
    ep_v[i] = p; er_v[i] = r;
  endtask

  task automatic start_mb(input int x, input int y, input logic i4);
    q_blk.delete(); q_prev.delete(); q_rem.delete(); q_cyc.delete(); q_done.delete();
    mb_x_in = 7'(x); mb_y_in = 7'(y); mb_is_i4_in = i4; mb_start_in = 1'b1;
    @(posedge clk); #1;
    mb_start_in = 1'b0;
  endtask

  task automatic accept_one(input logic [3:0] m);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    mode_valid_in = 1'b1; mode_in = m;
    do begin
      @(negedge clk); acc = mode_ready_out;
      @(posedge clk); #1; n++;
    end while (!acc && n < 64);
    chk("accept_in_time", 32'(acc), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    mode_valid_in = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); seen = mb_done_out; n++;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(mb_done_out), 32'd0);
    chk({tag, "_idle"}, 32'(busy_out), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic feed_mb(input string tag, input int stall_at);
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at && i > 0) begin
        mode_valid_in = 1'b1; mode_in = m_v[i]; flag_ready_in = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_ready", 32'(mode_ready_out), 32'd0);
          chk("stall_valid", 32'(flag_valid_out), 32'd1);
          chk("stall_blk",   32'(blk_idx_out), 32'(i - 1));
          chk("stall_prev",  32'(prev_flag_out), 32'(ep_v[i-1]));
          chk("stall_rem",   32'(rem_mode_out), 32'(er_v[i-1]));
          @(posedge clk); #1;
        end
        flag_ready_in = 1'b1;
      end
      accept_one(m_v[i]);
    end
    wait_done(tag);
    chk({tag, "_npairs"}, 32'(q_blk.size()), 32'd16);
    for (int i = 0; i < q_blk.size() && i < 16; i++) begin
      chk($sformatf("%s_blk%0d", tag, i),  32'(q_blk[i]), 32'(i));
      chk($sformatf("%s_prev%0d", tag, i), 32'(q_prev[i]), 32'(ep_v[i]));
      chk($sformatf("%s_rem%0d", tag, i),  32'(q_rem[i]), 32'(er_v[i]));
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(flag_valid_out), 32'd0);
    chk("rst_ready", 32'(mode_ready_out), 32'd0);
    chk("rst_busy",  32'(busy_out), 32'd0);
    chk("rst_done",  32'(mb_done_out), 32'd0);
    chk("rst_prev",  32'(prev_flag_out), 32'd0);
    chk("rst_rem",   32'(rem_mode_out), 32'd0);
    chk("rst_blk",   32'(blk_idx_out), 32'd0);
    chk("rst_err",   32'(mode_err_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MB (0,0): all DC, streaming at one block per cycle
    set_all(4'd2);
    start_mb(0, 0, 1'b1);
    feed_mb("mb00", -1);
    if (q_cyc.size() == 16) begin
      for (int i = 1; i < 16; i++)
        chk($sformatf("b2b%0d", i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd1);
    end
    chk("mb00_ndone", 32'(q_done.size()), 32'd1);
    if (q_done.size() > 0 && q_cyc.size() == 16)
      chk("mb00_done_lat", 32'(q_done[0] - q_cyc[15]), 32'd2);

    // MB (1,0): all mode 1, top row has no up neighbour
    set_all(4'd1);
    set_exp(0, 1'b0, 3'd1); set_exp(1, 1'b0, 3'd1);
    set_exp(4, 1'b0, 3'd1); set_exp(5, 1'b0, 3'd1);
    start_mb(1, 0, 1'b1);
    feed_mb("mb10", -1);

    // MB (2,0): non-I4, context filled with DC
    start_mb(2, 0, 1'b0);
    wait_done("fill");
    chk("fill_npairs", 32'(q_blk.size()), 32'd0);

    // MB (3,0): left from the filled MB, boundary modes 0 and 8
    set_all(4'd2);
    m_v[1] = 4'd4; m_v[10] = 4'd0; m_v[15] = 4'd8;
    set_exp(1, 1'b0, 3'd3); set_exp(10, 1'b0, 3'd0);
    set_exp(11, 1'b0, 3'd1); set_exp(15, 1'b0, 3'd7);
    start_mb(3, 0, 1'b1);
    feed_mb("mb30", -1);

    // MB (0,1): all mode 8; up row from MB (0,0) is DC
    set_all(4'd8);
    set_exp(0, 1'b0, 3'd7); set_exp(1, 1'b0, 3'd7); set_exp(2, 1'b0, 3'd7);
    set_exp(4, 1'b0, 3'd7); set_exp(5, 1'b0, 3'd7); set_exp(8, 1'b0, 3'd7);
    set_exp(10, 1'b0, 3'd7);
    start_mb(0, 1, 1'b1);
    feed_mb("mb01", -1);

    // MB (1,1): up=0x1111, left=0x8888, with a 5-cycle output stall
    set_all(4'd3);
    m_v[0] = 4'd0; m_v[1] = 4'd5; m_v[12] = 4'd6;
    set_exp(0, 1'b0, 3'd0); set_exp(1, 1'b0, 3'd4); set_exp(2, 1'b0, 3'd2);
    set_exp(4, 1'b0, 3'd2); set_exp(5, 1'b0, 3'd2); set_exp(12, 1'b0, 3'd5);
    start_mb(1, 1, 1'b1);
    feed_mb("mb11", 6);

    // asynchronous reset in the middle of an MB
    start_mb(2, 1, 1'b1);
    accept_one(4'd2); accept_one(4'd2); accept_one(4'd2);
    chk("pre_rst_valid", 32'(flag_valid_out), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(flag_valid_out), 32'd0);
    chk("arst_busy",  32'(busy_out), 32'd0);
    chk("arst_ready", 32'(mode_ready_out), 32'd0);
    chk("arst_blk",   32'(blk_idx_out), 32'd0);
    chk("arst_done",  32'(mb_done_out), 32'd0);
    chk("arst_err",   32'(mode_err_out), 32'd0);
    mode_valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // restart at MB (0,0) with an out-of-range mode in block 0
    set_all(4'd2);
    m_v[0] = 4'd12;
`ifdef INTRA4X4_MODE_CHECK_EN
    set_exp(0, 1'b1, 3'd0);
`else
    set_exp(0, 1'b0, 3'd3);
`endif
    start_mb(0, 0, 1'b1);
    feed_mb("mbbad", -1);
`ifdef INTRA4X4_MODE_CHECK_EN
    chk("mode_err", 32'(mode_err_out), 32'd1);
`else
    chk("mode_err", 32'(mode_err_out), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
